tdm_slot_sched: RTL and testbench

Frame aligner and time-slot scheduler for the ST-bus converter datapath. Tracks the 8 kHz frame from f0 and the c4 bit clock, and maintains slot and bit counters. Each slot, it grants the shared converter/counter datapath to one of NREQ requesters according to a CPU-programmable slot table. Sits between the ST-bus timing inputs and the converter counter instances.

---
 rtl/tdm_slot_sched.sv | 202 ++++++++++++++++++++
 tb/tb_tdm_slot_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_slot_sched.sv
// ST-bus frame aligner and per-slot scheduler for the shared converter datapath.
// Optional macro SLOT_REUSE_EN: idle slots are handed out round-robin among requesters.
module tdm_slot_sched #(
    parameter int NSLOT      = 32,
    parameter int NREQ       = 4,
    parameter int C4_PER_BIT = 2,
    parameter int SYNC_LOSS  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f0,
    input  logic                     c4,
    input  logic                     wr,
    input  logic [$clog2(NSLOT)-1:0] waddr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NSLOT)-1:0] slot_num,
    output logic [2:0]               bit_num,
    output logic                     slot_start,
    output logic                     frame_start,
    output logic                     sync_ok,
    output logic                     frame_err,
    output logic [1:0]               fsm_state
);

    localparam int SW        = $clog2(NSLOT);
    localparam int CW        = $clog2(C4_PER_BIT);
    localparam int PW        = SW + 3 + CW;
    localparam int FRAME_LEN = NSLOT * 8 * C4_PER_BIT;
    localparam int MW        = $clog2(SYNC_LOSS + 1);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        LOCKED   = 2'd1,
        FLYWHEEL = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] cnt;
    logic [MW-1:0] miss_cnt;
    logic          tick_q;
    logic          c4_s1, c4_s2, c4_s3;
    logic          f0_s1, f0_s2, f0_prev;
    logic          c4_rise, f0_det, wrap;
    logic [2:0]    tbl [NSLOT];
    logic [2:0]    entry;
    logic [1:0]    owner;
    logic [3:0]    req_x;
    logic [3:0]    grant_x;
    logic          unused_wdata;

    assign unused_wdata = ^wdata[6:2];
    assign c4_rise      = c4_s2 & ~c4_s3;
    assign f0_det       = c4_rise & ~f0_s2 & f0_prev;
    assign wrap         = (cnt == PW'(FRAME_LEN - 1));
    assign slot_num     = cnt[PW-1:CW+3];
    assign bit_num      = cnt[CW+2:CW];
    assign fsm_state    = state;

`ifdef SLOT_REUSE_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_next;
    logic [1:0] rr_idx;
    logic       rr_found;
`endif

    // Requester grant: a request level is sampled once per slot; the grant is held to slot end.
    always_comb begin
        req_x = '0;
        req_x[NREQ-1:0] = req;
        entry   = tbl[slot_num];
        owner   = entry[1:0];
        grant_x = '0;
        if (entry[2] && (int'(owner) < NREQ) && req_x[owner]) begin
            grant_x[owner] = 1'b1;
        end
`ifdef SLOT_REUSE_EN
        rr_next  = rr_ptr;
        rr_idx   = '0;
        rr_found = 1'b0;
        if (grant_x == 4'b0) begin
            for (int k = 0; k < NREQ; k++) begin
                rr_idx = 2'((int'(rr_ptr) + k) % NREQ);
                if (!rr_found && req_x[rr_idx]) begin
                    rr_found        = 1'b1;
                    grant_x[rr_idx] = 1'b1;
                    rr_next         = 2'((int'(rr_idx) + 1) % NREQ);
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c4_s1       <= 1'b0;
            c4_s2       <= 1'b0;
            c4_s3       <= 1'b0;
            f0_s1       <= 1'b1;
            f0_s2       <= 1'b1;
            f0_prev     <= 1'b1;
            state       <= HUNT;
            cnt         <= '0;
            miss_cnt    <= '0;
            tick_q      <= 1'b0;
            slot_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_ok     <= 1'b0;
            frame_err   <= 1'b0;
            grant       <= '0;
`ifdef SLOT_REUSE_EN
            rr_ptr      <= '0;
`endif
        end else begin
            c4_s1       <= c4;
            c4_s2       <= c4_s1;
            c4_s3       <= c4_s2;
            f0_s1       <= f0;
            f0_s2       <= f0_s1;
            tick_q      <= 1'b0;
            frame_err   <= 1'b0;
            slot_start  <= tick_q && (cnt[CW+2:0] == '0);
            frame_start <= tick_q && (cnt == '0);

            if (slot_start && state != HUNT) begin
                grant <= grant_x[NREQ-1:0];
`ifdef SLOT_REUSE_EN
                rr_ptr <= rr_next;
`endif
            end

            if (c4_rise) begin
                f0_prev <= f0_s2;
                case (state)
                    HUNT: begin
                        grant <= '0;
                        if (f0_det) begin
                            cnt      <= '0;
                            miss_cnt <= '0;
                            state    <= LOCKED;
                            sync_ok  <= 1'b1;
                            tick_q   <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        tick_q <= 1'b1;
                        cnt    <= cnt + PW'(1);
                        if (f0_det && !wrap) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                        end else if (wrap && !f0_det) begin
                            state    <= FLYWHEEL;
                            miss_cnt <= MW'(1);
                        end
                    end
                    FLYWHEEL: begin
                        tick_q <= 1'b1;
                        cnt    <= cnt + PW'(1);
                        if (f0_det) begin
                            frame_err <= !wrap;
                            cnt       <= '0;
                            miss_cnt  <= '0;
                            state     <= LOCKED;
                        end else if (wrap) begin
                            miss_cnt <= miss_cnt + MW'(1);
                            // Last tolerated miss: drop lock, park the counter and release the datapath.
                            if (miss_cnt == MW'(SYNC_LOSS - 1)) begin
                                state   <= HUNT;
                                sync_ok <= 1'b0;
                                tick_q  <= 1'b0;
                                cnt     <= '0;
                                grant   <= '0;
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                        grant <= '0;
                    end
                endcase
            end
        end
    end

    // Table write and readback; the arbiter reads the pre-write entry on a same-edge collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSLOT; i++) begin
                tbl[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (wr) begin
                tbl[waddr] <= {wdata[7], wdata[1:0]};
            end
            rdata <= {tbl[waddr][2], 5'b0, tbl[waddr][1:0]};
        end
    end

endmodule

// File: tb/tb_tdm_slot_sched.sv
// Directed bench for tdm_slot_sched: lock, slot grants, flywheel/loss, realign, reset.
// Expected grants follow SLOT_REUSE_EN when the macro is defined for the build.
`timescale 1ns/1ps
module tb_tdm_slot_sched;

    logic       clk = 1'b0;
    logic       c4 = 1'b0;
    logic       reset = 1'b1;
    logic       f0 = 1'b1;
    logic       wr = 1'b0;
    logic [4:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [3:0] req = '0;
    logic [7:0] rdata;
    logic [3:0] grant;
    logic [4:0] slot_num;
    logic [2:0] bit_num;
    logic       slot_start, frame_start, sync_ok, frame_err;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [3:0] gnt_q[$];
    logic [7:0] mtbl[32];
    logic [1:0] m_rr = '0;

    logic f0_run = 1'b0;
    logic inj_req = 1'b0;
    logic inj_ack = 1'b0;
    int   gap = 0;

    tdm_slot_sched dut (
        .clk(clk), .reset(reset), .f0(f0), .c4(c4), .wr(wr), .waddr(waddr),
        .wdata(wdata), .rdata(rdata), .req(req), .grant(grant), .slot_num(slot_num),
        .bit_num(bit_num), .slot_start(slot_start), .frame_start(frame_start),
        .sync_ok(sync_ok), .frame_err(frame_err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;
    always #30 c4 = ~c4;

    // f0 source: one c4-wide low pulse every 512 c4; an injected pulse re-phases the source.
    always begin
        @(negedge c4);
        if (inj_req != inj_ack) begin
            f0 = 1'b0;
            @(negedge c4);
            f0 = 1'b1;
            inj_ack = inj_req;
            gap = 510;
        end else if (!f0_run) begin
            gap = 0;
        end else if (gap == 0) begin
            f0 = 1'b0;
            @(negedge c4);
            f0 = 1'b1;
            gap = 510;
        end else begin
            gap = gap - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sig(input int which, input int limit, input string tag);
        bit ok;
        bit hit;
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (frame_err) ferr_cnt++;
            case (which)
                0:       hit = slot_start;
                1:       hit = frame_start;
                2:       hit = frame_err;
                default: hit = !sync_ok;
            endcase
            if (hit) ok = 1'b1;
        end
        chk({tag, "_event"}, 32'(ok), 32'd1);
    endtask

    task automatic write_tbl(input logic [4:0] a, input logic [7:0] d);
        wr = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        wr = 1'b0;
        mtbl[a] = d & 8'h83;
    endtask

    task automatic read_chk(input logic [4:0] a);
        waddr = a;
        @(negedge clk);
        chk("rdata", 32'(rdata), 32'(mtbl[a]));
    endtask

    task automatic model_grant(input int s, input logic [3:0] r, output logic [3:0] g);
        logic [7:0] e;
        logic [1:0] idx;
        bit found;
        e = mtbl[s];
        g = '0;
        found = 1'b0;
        idx = '0;
        if (e[7] && r[e[1:0]]) g[e[1:0]] = 1'b1;
`ifdef SLOT_REUSE_EN
        if (g == 4'b0) begin
            for (int k = 0; k < 4; k++) begin
                idx = m_rr + 2'(k);
                if (!found && r[idx]) begin
                    found = 1'b1;
                    g[idx] = 1'b1;
                    m_rr = idx + 2'd1;
                end
            end
        end
`endif
    endtask

    // Entered on the sample where frame_start is seen; walks n slots checking slot_num and grant.
    task automatic walk_slots(input logic [3:0] r, input int n, input bit extras);
        logic [3:0] g;
        longint ts;
        ts = 0;
        for (int s = 0; s < n; s++) exp_q.push_back(8'(s));
        for (int s = 0; s < n; s++) begin
            if (s > 0) wait_sig(0, 200, "slot_start");
            chk("slot_num", 32'(slot_num), 32'(exp_q.pop_front()));
            if (s == 1) ts = $time;
            if (s == 2) chk("slot_period_ns", 32'($time - ts), 32'd960);
            if (s == 0) req = r;
            if (extras && s == 9) begin
                wr = 1'b1;
                waddr = 5'd9;
                wdata = 8'h00;
            end
            model_grant(s, req, g);
            gnt_q.push_back(g);
            if (extras && s == 9) mtbl[9] = 8'h00;
            @(negedge clk);
            wr = 1'b0;
            chk("grant", 32'(grant), 32'(gnt_q.pop_front()));
            if (extras && s == 5) begin
                req = r & ~4'b0010;
                repeat (5) @(negedge clk);
                chk("grant_hold", 32'(grant), 32'(g));
                req = r;
            end
        end
    endtask

    initial begin
        longint t1;
        for (int i = 0; i < 32; i++) mtbl[i] = 8'h00;
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sync_ok", 32'(sync_ok), 32'd0);
        chk("rst_slot_num", 32'(slot_num), 32'd0);
        chk("rst_bit_num", 32'(bit_num), 32'd0);
        chk("rst_slot_start", 32'(slot_start), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        write_tbl(5'd5, 8'h81);
        write_tbl(5'd6, 8'h03);
        write_tbl(5'd9, 8'h82);
        write_tbl(5'd12, 8'hFE);
        write_tbl(5'd31, 8'h81);
        read_chk(5'd5);
        read_chk(5'd6);
        read_chk(5'd9);
        read_chk(5'd12);
        read_chk(5'd31);
        read_chk(5'd0);
        chk("hunt_sync_ok", 32'(sync_ok), 32'd0);
        chk("hunt_state", 32'(fsm_state), 32'd0);

        f0_run = 1'b1;
        wait_sig(1, 200, "lock_frame_start");
        chk("lock_sync_ok", 32'(sync_ok), 32'd1);
        chk("lock_state", 32'(fsm_state), 32'd1);
        t1 = $time;
        ferr_cnt = 0;
        walk_slots(4'b0010, 32, 1'b0);
        wait_sig(1, 200, "frame_start");
        chk("frame_period_ns", 32'($time - t1), 32'd30720);
        walk_slots(4'b0110, 32, 1'b1);
        wait_sig(1, 200, "frame_start");
        walk_slots(4'b0110, 32, 1'b0);
        wait_sig(1, 200, "frame_start");
        walk_slots(4'b0000, 32, 1'b0);
        chk("no_frame_err", 32'(ferr_cnt), 32'd0);

        // f0 stops: two flywheel frames keep sync, the third missing f0 drops to HUNT.
        req = 4'b0010;
        f0_run = 1'b0;
        wait_sig(1, 200, "fly1_frame_start");
        chk("fly1_sync_ok", 32'(sync_ok), 32'd1);
        chk("fly1_state", 32'(fsm_state), 32'd2);
        wait_sig(1, 3200, "fly2_frame_start");
        chk("fly2_sync_ok", 32'(sync_ok), 32'd1);
        chk("fly2_state", 32'(fsm_state), 32'd2);
        for (int s = 0; s < 40 && slot_num != 5'd31; s++) wait_sig(0, 200, "fly_slot_start");
        @(negedge clk);
        chk("fly_slot31_grant", 32'(grant), 32'b0010);
        wait_sig(3, 200, "sync_loss");
        chk("loss_grant", 32'(grant), 32'd0);
        chk("loss_state", 32'(fsm_state), 32'd0);
        chk("loss_slot_num", 32'(slot_num), 32'd0);

        f0_run = 1'b1;
        wait_sig(1, 200, "relock_frame_start");
        chk("relock_sync_ok", 32'(sync_ok), 32'd1);
        chk("relock_state", 32'(fsm_state), 32'd1);
        chk("relock_slot_num", 32'(slot_num), 32'd0);

        for (int s = 0; s < 40 && slot_num != 5'd10; s++) wait_sig(0, 200, "pre_inj_slot_start");
        chk("inj_slot", 32'(slot_num), 32'd10);
        ferr_cnt = 0;
        inj_req = ~inj_req;
        wait_sig(2, 200, "frame_err");
        wait_sig(0, 5, "realign_slot_start");
        chk("realign_slot_num", 32'(slot_num), 32'd0);
        chk("realign_frame_start", 32'(frame_start), 32'd1);
        chk("realign_sync_ok", 32'(sync_ok), 32'd1);
        req = 4'b0010;
        for (int s = 0; s < 40 && slot_num != 5'd5; s++) wait_sig(0, 200, "pre_rst_slot_start");
        @(negedge clk);
        chk("pre_rst_grant", 32'(grant), 32'b0010);
        chk("single_frame_err", 32'(ferr_cnt), 32'd1);

        reset = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_sync_ok", 32'(sync_ok), 32'd0);
        chk("arst_slot_num", 32'(slot_num), 32'd0);
        chk("arst_state", 32'(fsm_state), 32'd0);
        req = 4'b0000;
        m_rr = '0;
        for (int i = 0; i < 32; i++) mtbl[i] = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 32; a++) read_chk(5'(a));

        wait_sig(1, 3400, "reuse_frame_start");
        walk_slots(4'b1010, 8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
